// File: rtl/mem_dual_copier.sv
// mem_dual_copier: block copier driving both ports of a mem_dual RAM.
// Optional destination read-back check: define MEM_DUAL_COPIER_VERIFY_EN.
module mem_dual_copier #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    src_base,
    input  logic [AW-1:0]    dst_base,
    input  logic [AW:0]      length,
    output logic             busy,
    output logic             done,
`ifdef MEM_DUAL_COPIER_VERIFY_EN
    output logic             mismatch,
    output logic [AW-1:0]    mismatch_addr,
`endif
    output logic [AW-1:0]    address_0,
    output logic [WIDTH-1:0] data_0,
    output logic             wren_0,
    input  logic [WIDTH-1:0] q_0,
    output logic [AW-1:0]    address_1,
    output logic [WIDTH-1:0] data_1,
    output logic             wren_1,
    input  logic [WIDTH-1:0] q_1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DONE   = 2'd2
`ifdef MEM_DUAL_COPIER_VERIFY_EN
        , VERIFY = 2'd3
`endif
    } state_t;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic           issue;
    logic           in_run;
    logic [AW-1:0]  src_r;
    logic [AW-1:0]  dst_r;
    logic [AW:0]    len_r;
    logic [AW:0]    rd_cnt;
    logic [AW-1:0]  wr_ptr;
    logic           rd_v;

`ifdef MEM_DUAL_COPIER_VERIFY_EN
    logic           vissue;
    logic           rd_last;
    logic           chk_v1;
    logic           chk_v2;
    logic [AW-1:0]  chk_addr;
`endif

    // Port 0 never writes; port 1 write data is the word just read.
    assign data_0 = '0;
    assign wren_0 = 1'b0;
    assign data_1 = q_0;

`ifdef MEM_DUAL_COPIER_VERIFY_EN
    assign in_run  = (state == READ) || (state == VERIFY);
    assign rd_last = (state == READ) && !issue;
`else
    assign in_run  = (state == READ);
    logic unused_q_1;
    assign unused_q_1 = ^q_1;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and issue decisions; a start during the done pulse is dropped.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
`ifdef MEM_DUAL_COPIER_VERIFY_EN
        vissue     = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start && !done) begin
                    accept     = 1'b1;
                    state_next = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (rd_cnt < len_r) begin
                    issue = 1'b1;
                end else begin
`ifdef MEM_DUAL_COPIER_VERIFY_EN
                    state_next = VERIFY;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef MEM_DUAL_COPIER_VERIFY_EN
            VERIFY: begin
                if (rd_cnt < len_r) begin
                    vissue = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Copy datapath: registered read address, one-deep valid pipe to the write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= '0;
            rd_cnt    <= '0;
            wr_ptr    <= '0;
            rd_v      <= 1'b0;
            address_0 <= '0;
            address_1 <= '0;
            wren_1    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy   <= in_run;
            done   <= (state == DONE);
            rd_v   <= issue;
            wren_1 <= rd_v;
            if (accept) begin
                src_r  <= src_base;
                dst_r  <= dst_base;
                len_r  <= (length > LEN_MAX) ? LEN_MAX : length;
                rd_cnt <= '0;
                wr_ptr <= '0;
            end
            if (issue) begin
                address_0 <= src_r + rd_cnt[AW-1:0];
                rd_cnt    <= rd_cnt + 1'b1;
            end
            if (rd_v) begin
                address_1 <= dst_r + wr_ptr;
                wr_ptr    <= wr_ptr + 1'b1;
            end
`ifdef MEM_DUAL_COPIER_VERIFY_EN
            if (rd_last) begin
                rd_cnt <= '0;
            end
            if (vissue) begin
                address_0 <= src_r + rd_cnt[AW-1:0];
                address_1 <= dst_r + rd_cnt[AW-1:0];
                rd_cnt    <= rd_cnt + 1'b1;
            end
`endif
        end
    end

`ifdef MEM_DUAL_COPIER_VERIFY_EN
    // Read-back compare; only the first failing destination address is kept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chk_v1        <= 1'b0;
            chk_v2        <= 1'b0;
            chk_addr      <= '0;
            mismatch      <= 1'b0;
            mismatch_addr <= '0;
        end else begin
            chk_v1 <= vissue;
            chk_v2 <= chk_v1;
            if (chk_v1) begin
                chk_addr <= address_1;
            end
            if (accept) begin
                mismatch      <= 1'b0;
                mismatch_addr <= '0;
            end else if (chk_v2 && !mismatch && (q_0 != q_1)) begin
                mismatch      <= 1'b1;
                mismatch_addr <= chk_addr;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_dual_copier.sv
// tb_mem_dual_copier: directed bench for mem_dual_copier
// with a behavioural mem_dual model and a backdoor write port.
module tb_mem_dual_copier;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
`ifdef MEM_DUAL_COPIER_VERIFY_EN
    localparam int VX = 1;
`else
    localparam int VX = 0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    src_base;
    logic [AW-1:0]    dst_base;
    logic [AW:0]      length;
    logic             busy;
    logic             done;
    logic [AW-1:0]    address_0;
    logic [WIDTH-1:0] data_0;
    logic             wren_0;
    logic [WIDTH-1:0] q_0;
    logic [AW-1:0]    address_1;
    logic [WIDTH-1:0] data_1;
    logic             wren_1;
    logic [WIDTH-1:0] q_1;
`ifdef MEM_DUAL_COPIER_VERIFY_EN
    logic             mismatch;
    logic [AW-1:0]    mismatch_addr;
`endif

    logic             bd_we;
    logic [AW-1:0]    bd_addr;
    logic [WIDTH-1:0] bd_data;
    logic [WIDTH-1:0] mem [0:DEPTH-1];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int mon_gen = 0;
    int seen_gen = 0;
    int done_cnt, done_at, wr_cnt, busy_cnt, busy_first, busy_last;

    mem_dual_copier #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .length    (length),
        .busy      (busy),
        .done      (done),
`ifdef MEM_DUAL_COPIER_VERIFY_EN
        .mismatch      (mismatch),
        .mismatch_addr (mismatch_addr),
`endif
        .address_0 (address_0),
        .data_0    (data_0),
        .wren_0    (wren_0),
        .q_0       (q_0),
        .address_1 (address_1),
        .data_1    (data_1),
        .wren_1    (wren_1),
        .q_1       (q_1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // mem_dual model: registered read data, backdoor write wins.
    always @(posedge clock) begin
        if (wren_0) mem[address_0] <= data_0;
        if (wren_1) mem[address_1] <= data_1;
        if (bd_we) mem[bd_addr] <= bd_data;
        q_0 <= mem[address_0];
        q_1 <= mem[address_1];
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (seen_gen != mon_gen) begin
            seen_gen   = mon_gen;
            done_cnt   = 0;
            done_at    = -1;
            wr_cnt     = 0;
            busy_cnt   = 0;
            busy_first = -1;
            busy_last  = -1;
        end
        if (done) begin
            done_cnt++;
            done_at = cyc;
        end
        if (wren_1) wr_cnt++;
        if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [WIDTH-1:0] v);
        @(negedge clock);
        bd_we   = 1'b1;
        bd_addr = AW'(a);
        bd_data = v;
        @(posedge clock);
        #1;
        bd_we = 1'b0;
    endtask

    // rs_k: edge at which a second start is seen; bd_k: edge of a backdoor 0xFF write.
    task automatic run_copy(input int s, input int d, input int l,
                            input int rs_k, input int bd_k, input int bd_a);
        int nk;
        nk = 2 * ((l > DEPTH) ? DEPTH : l) + 12;
        @(negedge clock);
        start    = 1'b1;
        src_base = AW'(s);
        dst_base = AW'(d);
        length   = (AW+1)'(l);
        @(posedge clock);
        #1;
        start = 1'b0;
        t0    = cyc;
        mon_gen++;
        for (int k = 1; k <= nk; k++) begin
            if (k == rs_k) begin
                start    = 1'b1;
                src_base = 6'd0;
                dst_base = 6'd50;
                length   = 7'd1;
            end
            if (k == bd_k) begin
                bd_we   = 1'b1;
                bd_addr = AW'(bd_a);
                bd_data = 8'hFF;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            bd_we = 1'b0;
        end
    endtask

    task automatic copy_checks(input string tag, input int l);
        int le, ed, eb;
        le = (l > DEPTH) ? DEPTH : l;
        ed = (le == 0) ? 1 : le + 2 + VX * (le + 1);
        eb = (le == 0) ? 0 : le + 1 + VX * (le + 1);
        chk({tag, ":done_n"}, done_cnt, 1);
        chk({tag, ":done_t"}, done_at - t0, ed);
        chk({tag, ":wren_n"}, wr_cnt, le);
        chk({tag, ":busy_n"}, busy_cnt, eb);
        if (le != 0) begin
            chk({tag, ":busy_t0"}, busy_first - t0, 1);
            chk({tag, ":busy_run"}, busy_last - busy_first + 1, eb);
        end
    endtask

    initial begin
        logic [7:0] v4 [0:3];
        reset    = 1'b1;
        start    = 1'b0;
        src_base = '0;
        dst_base = '0;
        length   = '0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_data  = '0;
        for (int i = 0; i < DEPTH; i++) poke(i, 8'h00);

        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wren1", wren_1, 0);
        chk("rst_addr0", address_0, 0);
        chk("rst_addr1", address_1, 0);
        chk("rst_wren0", wren_0, 0);
        reset = 1'b0;

        v4[0] = 8'h11; v4[1] = 8'h22; v4[2] = 8'h33; v4[3] = 8'h44;
        for (int i = 0; i < 4; i++) poke(i, v4[i]);
        run_copy(0, 16, 4, -1, -1, 0);
        copy_checks("basic", 4);
        for (int i = 0; i < 4; i++) chk($sformatf("basic_d%0d", i), mem[16+i], v4[i]);

        poke(5, 8'h55);
        poke(9, 8'h99);
        run_copy(5, 9, 0, -1, -1, 0);
        copy_checks("len0", 0);
        chk("len0_dst", mem[9], 8'h99);

        v4[0] = 8'h0A; v4[1] = 8'h0B; v4[2] = 8'h0C; v4[3] = 8'h0D;
        poke(62, v4[0]); poke(63, v4[1]); poke(0, v4[2]); poke(1, v4[3]);
        run_copy(62, 30, 4, -1, -1, 0);
        copy_checks("srcwrap", 4);
        for (int i = 0; i < 4; i++) chk($sformatf("srcwrap_d%0d", i), mem[30+i], v4[i]);

        v4[0] = 8'h21; v4[1] = 8'h22; v4[2] = 8'h23; v4[3] = 8'h24;
        for (int i = 0; i < 4; i++) poke(2 + i, v4[i]);
        run_copy(2, 62, 4, -1, -1, 0);
        copy_checks("dstwrap", 4);
        chk("dstwrap_d0", mem[62], 8'h21);
        chk("dstwrap_d1", mem[63], 8'h22);
        chk("dstwrap_d2", mem[0], 8'h23);
        chk("dstwrap_d3", mem[1], 8'h24);

        run_copy(0, 0, 100, -1, -1, 0);
        copy_checks("clamp", 100);
        chk("clamp_keep", mem[16], 8'h11);

        for (int i = 0; i < 8; i++) poke(8 + i, 8'hA0 + 8'(i));
        poke(50, 8'h77);
        run_copy(8, 40, 8, 2, -1, 0);
        copy_checks("restart", 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("restart_d%0d", i), mem[40+i], 8'hA0 + 8'(i));
        chk("restart_ign", mem[50], 8'h77);

`ifdef MEM_DUAL_COPIER_VERIFY_EN
        chk("vfy_clean", mismatch, 0);
        run_copy(8, 24, 4, -1, 6, 26);
        copy_checks("vfy", 4);
        chk("vfy_flag", mismatch, 1);
        chk("vfy_addr", mismatch_addr, 26);
`endif

        for (int i = 0; i < 8; i++) poke(20 + i, 8'hEE);
        @(negedge clock);
        start    = 1'b1;
        src_base = 6'd8;
        dst_base = 6'd20;
        length   = 7'd8;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("arst_pre_wren", wren_1, 1);
        chk("arst_pre_busy", busy, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_wren", wren_1, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
`ifdef MEM_DUAL_COPIER_VERIFY_EN
        chk("arst_mism", mismatch, 0);
`endif
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++)
            chk($sformatf("arst_w%0d", i), mem[20+i], 8'hA0 + 8'(i));
        for (int i = 3; i < 8; i++)
            chk($sformatf("arst_u%0d", i), mem[20+i], 8'hEE);

        poke(0, 8'h5A);
        poke(1, 8'h5B);
        run_copy(0, 48, 2, -1, -1, 0);
        copy_checks("after", 2);
        chk("after_d0", mem[48], 8'h5A);
        chk("after_d1", mem[49], 8'h5B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
